// File: rtl/score_bcd_counter.sv
// score_bcd_counter
//   Three-digit BCD score counter (000-999) with best-score memory.
//   Each 0->1 transition of inc scores one point. clear ends the game: the
//   digits return to 000 and, if the finished score beats the stored best,
//   best is loaded and new_best pulses for one cycle.
//
// Parameters
//   SYNC_IN      1: inc passes through a 2-flop synchronizer before edge
//                   detection (points land 3 edges after inc rises)
//                0: inc is sampled directly (points land 1 edge after)
//
// Configuration macro
//   SCORE_SATURATE_EN  defined:   score saturates at 999, rollover tied 0
//                      undefined: score wraps 999->000, rollover pulses
//
// Ports
//   Clock     in   single rising-edge clock
//   Reset     in   asynchronous active-low reset
//   inc       in   score-event level, one point per 0->1 transition
//   clear     in   synchronous game-over/restart, active high
//   counter1  out  ones digit (BCD)
//   counter2  out  tens digit (BCD)
//   counter3  out  hundreds digit (BCD)
//   best      out  best score, BCD {hundreds,tens,ones}
//   new_best  out  one-cycle pulse when best is loaded
//   rollover  out  one-cycle pulse on 999->000 wrap

module score_bcd_counter #(
    parameter int unsigned SYNC_IN = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        inc,
    input  logic        clear,
    output logic [3:0]  counter1,
    output logic [3:0]  counter2,
    output logic [3:0]  counter3,
    output logic [11:0] best,
    output logic        new_best,
    output logic        rollover
);

    logic        inc_s;      // sample fed to the edge detector
    logic        sample_ok;  // inc_s reflects a real post-reset sample
    logic        inc_p;      // previous sample
    logic        point;

    logic [3:0]  ones_n;
    logic [3:0]  tens_n;
    logic [3:0]  hund_n;
    logic        wrap;
    logic [11:0] score;
    logic        at_max;
    logic        beat;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    generate
        if (SYNC_IN != 0) begin : g_sync
            logic [1:0] sync_q;
            logic [1:0] flush_q;

            // flush_q marks when the reset zeros have left the synchronizer,
            // so a level held high through reset is not mistaken for a rise.
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    sync_q  <= '0;
                    flush_q <= '0;
                end else begin
                    sync_q  <= {sync_q[0], inc};
                    flush_q <= {flush_q[0], 1'b1};
                end
            end

            assign inc_s     = sync_q[1];
            assign sample_ok = flush_q[1];
        end else begin : g_direct
            assign inc_s     = inc;
            assign sample_ok = 1'b1;
        end
    endgenerate

    // inc_p resets high so a level already high at release never counts;
    // it stays high until the sample path carries genuine post-reset data.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            inc_p <= 1'b1;
        end else begin
            inc_p <= sample_ok ? inc_s : 1'b1;
        end
    end

    assign point = inc_s & ~inc_p;

    // ------------------------------------------------------------------
    // BCD increment
    // ------------------------------------------------------------------
    assign score  = {counter3, counter2, counter1};
    assign at_max = (score == 12'h999);
    // BCD ordering matches decimal ordering, so a plain unsigned compare works
    assign beat   = (score > best);

    always_comb begin
        ones_n = counter1;
        tens_n = counter2;
        hund_n = counter3;
        wrap   = 1'b0;
        if (point) begin
            if (at_max) begin
`ifndef SCORE_SATURATE_EN
                ones_n = '0;
                tens_n = '0;
                hund_n = '0;
                wrap   = 1'b1;
`endif
            end else if (counter1 == 4'd9) begin
                ones_n = '0;
                if (counter2 == 4'd9) begin
                    tens_n = '0;
                    hund_n = counter3 + 4'd1;
                end else begin
                    tens_n = counter2 + 4'd1;
                end
            end else begin
                ones_n = counter1 + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Score / best registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            counter1 <= '0;
            counter2 <= '0;
            counter3 <= '0;
            best     <= '0;
            new_best <= 1'b0;
        end else begin
            new_best <= 1'b0;
            if (clear) begin
                // a point arriving with clear is discarded
                counter1 <= '0;
                counter2 <= '0;
                counter3 <= '0;
                if (beat) begin
                    best     <= score;
                    new_best <= 1'b1;
                end
            end else begin
                counter1 <= ones_n;
                counter2 <= tens_n;
                counter3 <= hund_n;
            end
        end
    end

`ifdef SCORE_SATURATE_EN
    assign rollover = 1'b0;
`else
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rollover <= 1'b0;
        end else begin
            rollover <= wrap & ~clear;
        end
    end
`endif

endmodule

// File: doc/score_bcd_counter.md
SCORE_BCD_COUNTER -- requirements
Module: score_bcd_counter

Interface
REQ-001 SHALL have parameter SYNC_IN, default 1: 1 = inc passes through a 2-flop synchronizer before edge detection; 0 = inc is sampled directly.
REQ-002 SHALL have port Clock  input  1  the single clock, all flops rise-edge triggered.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port inc  input  1  score-event level; each 0->1 transition is one point.
REQ-005 SHALL have port clear  input  1  synchronous game-over/restart; active-high.
REQ-006 SHALL have port counter1  output  4  ones digit of current score, BCD 0-9.
REQ-007 SHALL have port counter2  output  4  tens digit of current score, BCD 0-9.
REQ-008 SHALL have port counter3  output  4  hundreds digit of current score, BCD 0-9.
REQ-009 SHALL have port best  output  12  best score, BCD {hundreds,tens,ones}.
REQ-010 SHALL have port new_best  output  1  one-cycle pulse when best is updated.
REQ-011 SHALL have port rollover  output  1  one-cycle pulse on 999->000 wrap.

Function
REQ-012 SHALL detect a point as inc_s=1 while previous sample inc_p=0, where inc_s is inc (SYNC_IN=0) or the 2nd synchronizer stage (SYNC_IN=1).
REQ-013 SHALL register every point-driven count change on the same edge the point is detected: latency inc rise -> digits change is 1 edge (SYNC_IN=0) or 3 edges (SYNC_IN=1).
REQ-014 SHALL count strictly in BCD: ones 9->0 carries to tens; tens 9->0 with carry carries to hundreds; no digit ever holds 10-15.
REQ-015 SHALL count at most one point per clock; an inc held high counts once.
REQ-016 SHALL, on clear=1 at an edge, load digits to 0,0,0; clear has priority over a simultaneous point, which is discarded.
REQ-017 SHALL, on clear=1, compare {counter3,counter2,counter1} to best as unsigned 12-bit values; if strictly greater, load best with the score and pulse new_best on that same edge.
REQ-018 SHALL keep best unchanged on equal or lower score; best changes only on clear or Reset.
REQ-019 SHALL drive new_best and rollover low in every cycle other than their defined pulse cycle.
REQ-020 SHALL keep all outputs registered (no combinational path from inc/clear to outputs).

Reset
REQ-021 SHALL, while Reset=0, asynchronously force counter1..3=0, best=12'h000, new_best=0, rollover=0, synchronizer stages=0.
REQ-022 SHALL reset inc_p to 1 so an inc held high through Reset deassertion does not count a point.
REQ-023 SHALL abandon any in-flight synchronized point when Reset asserts mid-operation; no count occurs after release unless inc makes a new 0->1 transition.

Configuration
REQ-024 SHALL, when macro SCORE_SATURATE_EN is defined, saturate at 999: points at 999 are ignored, digits hold 9,9,9, rollover is tied 0.
REQ-025 SHALL, when SCORE_SATURATE_EN is undefined, wrap 999->000 on a point and pulse rollover for that one cycle.

Verification
REQ-026 SHALL verify: SYNC_IN=0, Reset release, 12 single-cycle inc pulses -> counter3,2,1 = 0,1,2 after the 12th pulse edge.
REQ-027 SHALL verify: SYNC_IN=1, inc rises at edge 0 -> digits change at edge 3; inc held high 10 cycles -> exactly +1.
REQ-028 SHALL verify: score 099 plus one point -> 100; score 999 plus one point -> 000 with rollover=1 one cycle (macro off) or 999 with rollover=0 (macro on).
REQ-029 SHALL verify: score 042, best 000, clear -> best=12'h042, new_best=1 one cycle, digits 000; then score 042 again, clear -> best stays 042, new_best=0.
REQ-030 SHALL verify: inc high during Reset=0, release with inc still high -> no count; clear and point on same edge -> digits 000.
